correlator_cmd_encoder: RTL and testbench

//   Host-side command transmitter for the correlator UART control channel. On start it captures

---
 rtl/correlator_cmd_encoder.sv | 184 ++++++++++++++++++
 tb/tb_correlator_cmd_encoder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/correlator_cmd_encoder.sv
// Host-side command encoder for the correlator UART control channel: streams one
// command frame per start. Define CMD_CHANGED_ONLY_EN to skip unchanged SET runs.
module correlator_cmd_encoder #(
    parameter logic [63:0] INIT_SAMPLE_TIME = 64'd100,
    parameter logic [31:0] INIT_ACTIVE_LINE = 32'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [63:0] sample_time,
    input  logic [31:0] active_line,
    input  logic        transmit_enable,
    input  logic        sample_clock_enable,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic [2:0]  dbg_state
);

    // Handshake: a byte transfers on a posedge where tx_valid && tx_ready; tx_data and
    // tx_valid are held while tx_valid && !tx_ready, and tx_valid stays high for the frame.

    localparam logic [3:0] OP_RESET           = 4'd0;
    localparam logic [3:0] OP_SET_SAMPLE_TIME = 4'd1;
    localparam logic [3:0] OP_SET_ACTIVE_LINE = 4'd2;
    localparam logic [3:0] OP_ENABLE_MODULES  = 4'd12;
    localparam logic [3:0] OP_COMMIT          = 4'd13;

`ifdef CMD_CHANGED_ONLY_EN
    localparam logic CHANGED_ONLY = 1'b1;
`else
    localparam logic CHANGED_ONLY = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ST_RST = 3'd1,
        S_ST_NIB = 3'd2,
        S_AL_RST = 3'd3,
        S_AL_NIB = 3'd4,
        S_ENABLE = 3'd5,
        S_COMMIT = 3'd6
    } state_t;

    state_t      state, state_n, tgt_state;
    logic [3:0]  cnt, cnt_n, tgt_cnt;
    logic [7:0]  tx_data_n, tgt_byte;
    logic        tx_valid_n, busy_n, done_n;
    logic        adv, capture, commit, accept;
    logic [63:0] cap_st, shadow_st, src_st;
    logic [31:0] cap_al, shadow_al, src_al;
    logic        cap_te, cap_sce, src_te, src_sce;
    logic        st_skip, al_skip;

    assign accept    = tx_valid & tx_ready;
    assign dbg_state = state;

    // In IDLE the first byte is built straight from the inputs being captured this edge.
    assign src_st  = (state == S_IDLE) ? sample_time         : cap_st;
    assign src_al  = (state == S_IDLE) ? active_line         : cap_al;
    assign src_te  = (state == S_IDLE) ? transmit_enable     : cap_te;
    assign src_sce = (state == S_IDLE) ? sample_clock_enable : cap_sce;
    assign st_skip = CHANGED_ONLY && (src_st == shadow_st);
    assign al_skip = CHANGED_ONLY && (src_al == shadow_al);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        tx_data_n  = tx_data;
        tx_valid_n = tx_valid;
        busy_n     = busy;
        done_n     = 1'b0;
        adv        = 1'b0;
        capture    = 1'b0;
        commit     = 1'b0;
        tgt_state  = state;
        tgt_cnt    = 4'd0;
        tgt_byte   = 8'h00;

        case (state)
            S_IDLE: begin
                adv       = start;
                capture   = start;
                tgt_state = st_skip ? (al_skip ? S_ENABLE : S_AL_RST) : S_ST_RST;
            end
            S_ST_RST: begin
                adv       = accept;
                tgt_state = S_ST_NIB;
            end
            S_ST_NIB: begin
                adv = accept;
                if (cnt == 4'd15) begin
                    tgt_state = al_skip ? S_ENABLE : S_AL_RST;
                end else begin
                    tgt_state = S_ST_NIB;
                    tgt_cnt   = cnt + 4'd1;
                end
            end
            S_AL_RST: begin
                adv       = accept;
                tgt_state = S_AL_NIB;
            end
            S_AL_NIB: begin
                adv = accept;
                if (cnt == 4'd7) begin
                    tgt_state = S_ENABLE;
                end else begin
                    tgt_state = S_AL_NIB;
                    tgt_cnt   = cnt + 4'd1;
                end
            end
            S_ENABLE: begin
                adv       = accept;
                tgt_state = S_COMMIT;
            end
            S_COMMIT: begin
                adv       = accept;
                commit    = accept;
                tgt_state = S_IDLE;
            end
            default: begin
                adv       = 1'b1;
                tgt_state = S_IDLE;
            end
        endcase

        case (tgt_state)
            S_ST_RST: tgt_byte = {OP_SET_SAMPLE_TIME, OP_RESET};
            S_ST_NIB: tgt_byte = {src_st[{tgt_cnt, 2'b00} +: 4], OP_SET_SAMPLE_TIME};
            S_AL_RST: tgt_byte = {OP_SET_ACTIVE_LINE, OP_RESET};
            S_AL_NIB: tgt_byte = {src_al[{tgt_cnt[2:0], 2'b00} +: 4], OP_SET_ACTIVE_LINE};
            S_ENABLE: tgt_byte = {2'b00, src_sce, src_te, OP_ENABLE_MODULES};
            S_COMMIT: tgt_byte = {4'h0, OP_COMMIT};
            default:  tgt_byte = 8'h00;
        endcase

        if (adv) begin
            state_n    = tgt_state;
            cnt_n      = tgt_cnt;
            tx_data_n  = tgt_byte;
            tx_valid_n = (tgt_state != S_IDLE);
            busy_n     = (tgt_state != S_IDLE);
            done_n     = commit;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cap_st    <= 64'd0;
            cap_al    <= 32'd0;
            cap_te    <= 1'b0;
            cap_sce   <= 1'b0;
            shadow_st <= INIT_SAMPLE_TIME;
            shadow_al <= INIT_ACTIVE_LINE;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            tx_data  <= tx_data_n;
            tx_valid <= tx_valid_n;
            busy     <= busy_n;
            done     <= done_n;
            if (capture) begin
                cap_st  <= sample_time;
                cap_al  <= active_line;
                cap_te  <= transmit_enable;
                cap_sce <= sample_clock_enable;
            end
            // Shadows track what the correlator holds once a frame is committed.
            if (commit) begin
                shadow_st <= cap_st;
                shadow_al <= cap_al;
            end
        end
    end

endmodule

// File: tb/tb_correlator_cmd_encoder.sv
// Directed bench for correlator_cmd_encoder: frame contents, stalls, ignored restarts,
// mid-frame reset and the CMD_CHANGED_ONLY_EN skip behaviour.
module tb_correlator_cmd_encoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] sample_time = 64'd0;
  logic [31:0] active_line = 32'd0;
  logic        transmit_enable = 1'b0;
  logic        sample_clock_enable = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  logic [7:0]  exp_q[$];
  logic [63:0] m_shadow_st = 64'd100;
  logic [31:0] m_shadow_al = 32'd0;

  correlator_cmd_encoder dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .start               (start),
    .sample_time         (sample_time),
    .active_line         (active_line),
    .transmit_enable     (transmit_enable),
    .sample_clock_enable (sample_clock_enable),
    .tx_data             (tx_data),
    .tx_valid            (tx_valid),
    .tx_ready            (tx_ready),
    .busy                (busy),
    .done                (done),
    .dbg_state           (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start = 1'b0;
    tx_ready = 1'b1;
    tick();
    tick();
    m_shadow_st = 64'd100;
    m_shadow_al = 32'd0;
    reset_n = 1'b1;
    tick();
  endtask

  // Small frame model; only consulted where no hand-written vector is given.
  task automatic push_frame(input logic [63:0] st, input logic [31:0] al,
                            input logic te, input logic sce);
    logic skip_st;
    logic skip_al;
    skip_st = 1'b0;
    skip_al = 1'b0;
`ifdef CMD_CHANGED_ONLY_EN
    skip_st = (st == m_shadow_st);
    skip_al = (al == m_shadow_al);
`endif
    if (!skip_st) begin
      exp_q.push_back(8'h10);
      for (int k = 0; k < 16; k++) exp_q.push_back({st[4*k +: 4], 4'h1});
    end
    if (!skip_al) begin
      exp_q.push_back(8'h20);
      for (int k = 0; k < 8; k++) exp_q.push_back({al[4*k +: 4], 4'h2});
    end
    exp_q.push_back({2'b00, sce, te, 4'hC});
    exp_q.push_back(8'h0D);
  endtask

  task automatic push_hand_t1();
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h61);
    for (int k = 0; k < 14; k++) exp_q.push_back(8'h01);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h32);
    for (int k = 0; k < 7; k++) exp_q.push_back(8'h02);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h0D);
  endtask

  task automatic push_hand_t5();
    exp_q.push_back(8'h10);
    for (int k = 0; k < 16; k++) exp_q.push_back(8'hF1);
    exp_q.push_back(8'h20);
    for (int k = 0; k < 8; k++) exp_q.push_back(8'hF2);
    exp_q.push_back(8'h0C);
    exp_q.push_back(8'h0D);
  endtask

  // Starts one frame and drains it against exp_q (filled here when use_model is set).
  task automatic run_frame(input string name, input logic [63:0] st, input logic [31:0] al,
                           input logic te, input logic sce, input bit use_model,
                           input bit rand_ready, input int disturb_at, input int abort_at);
    int   n_exp;
    int   accepted;
    int   busy_cycles;
    int   cycles;
    bit   got_done;
    bit   stalled;
    bit   disturbed;
    bit   go;
    logic [7:0] prev_data;
    logic [7:0] data;
    if (use_model) push_frame(st, al, te, sce);
    n_exp = exp_q.size();
    sample_time = st;
    active_line = al;
    transmit_enable = te;
    sample_clock_enable = sce;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, "_start_busy"}, busy, 1);
    check({name, "_start_valid"}, tx_valid, 1);
    accepted = 0;
    busy_cycles = 0;
    cycles = 0;
    got_done = 0;
    stalled = 0;
    disturbed = 0;
    prev_data = 8'h00;
    while (!got_done && cycles < 2000) begin
      if (busy) busy_cycles++;
      check({name, "_valid_hold"}, tx_valid, 1);
      if (stalled) check({name, "_stall_data"}, tx_data, prev_data);
      if (abort_at >= 0 && accepted == abort_at) begin
        reset_n = 1'b0;
        #1;
        check({name, "_abort_valid"}, tx_valid, 0);
        check({name, "_abort_busy"}, busy, 0);
        check({name, "_abort_done"}, done, 0);
        check({name, "_abort_data"}, tx_data, 8'h00);
        tick();
        check({name, "_abort_done2"}, done, 0);
        m_shadow_st = 64'd100;
        m_shadow_al = 32'd0;
        exp_q.delete();
        reset_n = 1'b1;
        tx_ready = 1'b1;
        tick();
        check({name, "_abort_idle_valid"}, tx_valid, 0);
        return;
      end
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (disturb_at >= 0 && accepted == disturb_at && !disturbed) begin
        start = 1'b1;
        sample_time = ~st;
        active_line = ~al;
        transmit_enable = ~te;
        sample_clock_enable = ~sce;
        disturbed = 1;
      end else begin
        start = 1'b0;
      end
      go = tx_valid && tx_ready;
      data = tx_data;
      prev_data = tx_data;
      stalled = tx_valid && !tx_ready;
      tick();
      cycles++;
      if (go) begin
        accepted++;
        if (exp_q.size() == 0) check({name, "_extra_byte"}, data, 8'hXX);
        else check({name, "_byte"}, data, exp_q.pop_front());
      end
      if (done) got_done = 1;
    end
    start = 1'b0;
    tx_ready = 1'b1;
    check({name, "_done_seen"}, got_done, 1);
    check({name, "_byte_count"}, accepted, n_exp);
    check({name, "_end_valid"}, tx_valid, 0);
    check({name, "_end_busy"}, busy, 0);
    if (!rand_ready) check({name, "_busy_cycles"}, busy_cycles, n_exp);
    m_shadow_st = st;
    m_shadow_al = al;
    tick();
    check({name, "_done_width"}, done, 0);
  endtask

  initial begin
    do_reset();
    reset_n = 1'b0;
    #1;
    check("reset_data", tx_data, 8'h00);
    check("reset_valid", tx_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_state", dbg_state, 0);
    tick();
    reset_n = 1'b1;
    tick();

`ifdef CMD_CHANGED_ONLY_EN
    run_frame("t1", 64'h64, 32'd3, 1'b1, 1'b1, 1, 0, -1, -1);
`else
    push_hand_t1();
    run_frame("t1", 64'h64, 32'd3, 1'b1, 1'b1, 0, 0, -1, -1);
`endif

    run_frame("t2", 64'h64, 32'd3, 1'b1, 1'b1, 1, 1, -1, -1);

    run_frame("t3", 64'h0123_4567_89AB_CDEF, 32'hA5C3_0F19, 1'b0, 1'b1, 1, 0, 5, -1);
    for (int i = 0; i < 5; i++) begin
      check("t3_no_second_valid", tx_valid, 0);
      check("t3_no_second_busy", busy, 0);
      tick();
    end

    run_frame("t4", 64'h64, 32'd3, 1'b1, 1'b1, 1, 0, -1, 10);
`ifdef CMD_CHANGED_ONLY_EN
    run_frame("t4_next", 64'h64, 32'd3, 1'b1, 1'b1, 1, 0, -1, -1);
`else
    push_hand_t1();
    run_frame("t4_next", 64'h64, 32'd3, 1'b1, 1'b1, 0, 0, -1, -1);
`endif

`ifdef CMD_CHANGED_ONLY_EN
    run_frame("t5", 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 0, -1, -1);
`else
    push_hand_t5();
    run_frame("t5", 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 0, -1, -1);
`endif

    do_reset();
`ifdef CMD_CHANGED_ONLY_EN
    exp_q.push_back(8'h1C);
    exp_q.push_back(8'h0D);
    run_frame("t6a", 64'd100, 32'd0, 1'b1, 1'b0, 0, 0, -1, -1);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h52);
    for (int k = 0; k < 7; k++) exp_q.push_back(8'h02);
    exp_q.push_back(8'h1C);
    exp_q.push_back(8'h0D);
    run_frame("t6b", 64'd100, 32'd5, 1'b1, 1'b0, 0, 0, -1, -1);
`else
    run_frame("t6a", 64'd100, 32'd0, 1'b1, 1'b0, 1, 0, -1, -1);
    run_frame("t6b", 64'd100, 32'd5, 1'b1, 1'b0, 1, 0, -1, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
